cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 SHALL have no parameters; 2 compare channels, 32-bit data, fixed.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk        in   1   single clock, all logic on rising edge
  Rst        in   1   asynchronous active-low reset
  cs         in   1   MMIO select
  we         in   1   MMIO write enable (qualified by cs)
  addr       in   3   MMIO word offset
  wdata      in   32  MMIO write data
  rdata      out  32  MMIO read data, registered
  cnt_dout   in   32  free-running cycle counter value
  cnt_ovflw  in   1   counter overflow flag
  cnt_zero   out  1   counter clear, one-cycle pulse
  irq        out  1   level interrupt request
  irq_ack    in   1   interrupt acknowledge, one-cycle pulse

Function
REQ-003 Register map SHALL be: 0 CTRL, 1 CMP0, 2 CMP1, 3 STATUS, 4 CNT (read-only mirror of cnt_dout); other offsets read 0, writes ignored.
REQ-004 CTRL bits SHALL be: [0] EN global, [1] CLR write-only self-clearing, [2] CH0_EN, [3] CH1_EN, [4] CH0_PER, [5] CH1_PER, [6] OVF_IE; CLR reads 0.
REQ-005 Writes (cs & we) SHALL take effect on the next rising edge; reads (cs & !we) SHALL present data on rdata one cycle later, rdata holding value otherwise.
REQ-006 Writing CTRL with CLR=1 SHALL drive cnt_zero high for exactly the following cycle.
REQ-007 Each channel SHALL run FSM IDLE -> ARMED -> FIRED -> (ARMED if PER else DONE).
REQ-008 IDLE -> ARMED when EN & CHn_EN & CMPn != 0; target tgt_n <= cnt_dout + CMPn, mod 2^32.
REQ-009 ARMED -> FIRED on the cycle cnt_dout == tgt_n; STATUS pending bit n SHALL set on the next edge.
REQ-010 FIRED SHALL last one cycle; periodic: tgt_n <= tgt_n + CMPn mod 2^32, return to ARMED; one-shot: DONE.
REQ-011 DONE -> ARMED on a CMPn write with CHn_EN set; any state -> IDLE when EN or CHn_EN cleared or CMPn written 0.
REQ-012 Write to CMPn while ARMED SHALL re-arm with tgt_n <= cnt_dout + new CMPn.
REQ-013 On a CLR pulse, ARMED/DONE channels SHALL re-arm with tgt_n <= CMPn (counter restarts at 0).
REQ-014 STATUS bits SHALL be: [0] CH0 pending, [1] CH1 pending, [2] OVF sticky; write-1-to-clear.
REQ-015 irq SHALL equal OR of pending bits (plus REQ-021 term), registered, asserted the cycle after the pending bit sets.
REQ-016 irq_ack SHALL clear exactly one pending bit, highest priority first: CH0, then CH1, then OVF.
REQ-017 Simultaneous set and clear (W1C or ack) of the same bit: set SHALL win.
REQ-018 Both channels matching the same cycle SHALL both set pending; acks service CH0 first.

Reset
REQ-019 Rst low SHALL immediately clear all registers, tgt_n, STATUS, FSMs to IDLE, and drive rdata=0, cnt_zero=0, irq=0, regardless of clock; operation resumes on first edge after Rst high.

Configuration
REQ-020 Macro CNT_SCHED_OVF_IRQ_EN SHALL control the overflow feature.
REQ-021 Defined: rising edge of cnt_ovflw sets STATUS[2]; irq includes STATUS[2] & CTRL[6].
REQ-022 Undefined: STATUS[2] and CTRL[6] read 0, writes ignored, overflow never affects irq.

Verification
REQ-023 Reset: Rst low mid-ARMED with pending set -> rdata=0, irq=0, cnt_zero=0 same cycle; CTRL reads 0 after release.
REQ-024 One-shot: CMP0=100, CTRL=0x05 at cnt=50 -> pending[0] sets when cnt=150 (+1 edge), irq next cycle; no refire at 250.
REQ-025 Periodic wrap: cnt=0xFFFFFFF0, CMP1=0x20, CTRL=0x29 -> matches at 0x10, 0x30, 0x50; each ack clears irq.
REQ-026 Priority: both channels pending, irq_ack pulses twice -> STATUS 0x3 -> 0x2 -> 0x0, irq drops after second.
REQ-027 Clear: write CTRL=0x07 -> cnt_zero high one cycle; CH0 with CMP0=10 fires at cnt=10.
REQ-028 Overflow (macro defined, CTRL[6]=1): cnt_ovflw 0->1 -> STATUS=0x4, irq=1; undefined -> STATUS=0, irq=0.

Source files
------------

// File: rtl/cnt_sched.sv
// cnt_sched: two compare channels scheduled against an external free-running counter, MMIO-controlled.
// Define CNT_SCHED_OVF_IRQ_EN to enable the sticky counter-overflow status bit and its interrupt.
module cnt_sched (
  input  logic        clk,
  input  logic        Rst,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] cnt_dout,
  input  logic        cnt_ovflw,
  output logic        cnt_zero,
  output logic        irq,
  input  logic        irq_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FIRED = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CMP0   = 3'd1;
  localparam logic [2:0] A_CMP1   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_CNT    = 3'd4;

`ifdef CNT_SCHED_OVF_IRQ_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  // CLR (bit 1) is never stored, so it always reads back as 0
  localparam logic [6:0] CTRL_MASK = {OVF_EN, 6'b111101};
  localparam logic [2:0] STAT_MASK = {OVF_EN, 2'b11};

  // Acknowledge services the highest-priority pending source only: CH0, CH1, then OVF
  function automatic logic [2:0] ack_pick(input logic [2:0] pend);
    logic [2:0] sel;
    if (pend[0]) begin
      sel = 3'b001;
    end else if (pend[1]) begin
      sel = 3'b010;
    end else if (pend[2]) begin
      sel = 3'b100;
    end else begin
      sel = 3'b000;
    end
    return sel;
  endfunction

  logic [6:0]        ctrl_r;
  logic [1:0][31:0]  cmp_r;
  logic [1:0][31:0]  tgt_r;
  logic [1:0][1:0]   st_r;
  logic [2:0]        status_r;
  logic              ovf_d_r;
  logic [31:0]       rdata_r;
  logic              cnt_zero_r;
  logic              irq_r;

  logic              rd_s;
  logic              wr_ctrl_s;
  logic              wr_stat_s;
  logic [1:0]        wr_cmp_s;
  logic              clr_s;
  logic [6:0]        ctrl_nx_s;
  logic [31:0]       base_s;
  logic [1:0][31:0]  cmp_nx_s;
  logic [1:0][31:0]  tgt_nx_s;
  logic [1:0][1:0]   st_nx_s;
  logic [1:0]        fire_s;
  logic [2:0]        set_s;
  logic [2:0]        clr_bits_s;
  logic [2:0]        status_nx_s;
  logic              irq_nx_s;
  logic [31:0]       rd_val_s;

  assign rd_s        = cs & ~we;
  assign wr_ctrl_s   = cs & we & (addr == A_CTRL);
  assign wr_stat_s   = cs & we & (addr == A_STATUS);
  assign wr_cmp_s[0] = cs & we & (addr == A_CMP0);
  assign wr_cmp_s[1] = cs & we & (addr == A_CMP1);
  assign clr_s       = wr_ctrl_s & wdata[1];
  // Decisions see the value being written this cycle, so arming lines up with the write's cnt_dout
  assign ctrl_nx_s   = wr_ctrl_s ? (wdata[6:0] & CTRL_MASK) : ctrl_r;
  // A clear restarts the counter from 0, so targets become relative to zero
  assign base_s      = clr_s ? 32'd0 : cnt_dout;

  // Per-channel compare FSM and target update
  always_comb begin
    st_nx_s  = st_r;
    tgt_nx_s = tgt_r;
    cmp_nx_s = cmp_r;
    fire_s   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cmp_nx_s[i] = wr_cmp_s[i] ? wdata : cmp_r[i];
      if (!(ctrl_nx_s[0] && ctrl_nx_s[2+i]) || (cmp_nx_s[i] == 32'd0)) begin
        st_nx_s[i] = ST_IDLE;
      end else if ((st_r[i] == ST_IDLE) || clr_s || wr_cmp_s[i]) begin
        st_nx_s[i]  = ST_ARMED;
        tgt_nx_s[i] = base_s + cmp_nx_s[i];
      end else begin
        case (st_r[i])
          ST_ARMED: begin
            if (cnt_dout == tgt_r[i]) begin
              st_nx_s[i] = ST_FIRED;
              fire_s[i]  = 1'b1;
            end else begin
              st_nx_s[i] = ST_ARMED;
            end
          end
          ST_FIRED: begin
            if (ctrl_nx_s[4+i]) begin
              st_nx_s[i]  = ST_ARMED;
              tgt_nx_s[i] = tgt_r[i] + cmp_r[i];
            end else begin
              st_nx_s[i] = ST_DONE;
            end
          end
          ST_DONE: st_nx_s[i] = ST_DONE;
          default: st_nx_s[i] = ST_IDLE;
        endcase
      end
    end
  end

  // Pending bits: set has priority over W1C and acknowledge in the same cycle
  always_comb begin
    set_s[1:0] = fire_s;
    set_s[2]   = OVF_EN & cnt_ovflw & ~ovf_d_r;
    if (wr_stat_s) begin
      clr_bits_s = wdata[2:0] & STAT_MASK;
    end else begin
      clr_bits_s = 3'b000;
    end
    if (irq_ack) begin
      clr_bits_s = clr_bits_s | ack_pick(status_r);
    end else begin
      clr_bits_s = clr_bits_s;
    end
    status_nx_s = ((status_r & ~clr_bits_s) | set_s) & STAT_MASK;
    irq_nx_s    = status_r[0] | status_r[1] | (status_r[2] & ctrl_r[6]);
  end

  // MMIO read data selection
  always_comb begin
    case (addr)
      A_CTRL:   rd_val_s = {25'd0, ctrl_r};
      A_CMP0:   rd_val_s = cmp_r[0];
      A_CMP1:   rd_val_s = cmp_r[1];
      A_STATUS: rd_val_s = {29'd0, status_r};
      A_CNT:    rd_val_s = cnt_dout;
      default:  rd_val_s = 32'd0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      ctrl_r     <= 7'd0;
      cmp_r      <= '0;
      tgt_r      <= '0;
      st_r       <= {ST_IDLE, ST_IDLE};
      status_r   <= 3'd0;
      ovf_d_r    <= 1'b0;
      rdata_r    <= 32'd0;
      cnt_zero_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_nx_s;
      cmp_r      <= cmp_nx_s;
      tgt_r      <= tgt_nx_s;
      st_r       <= st_nx_s;
      status_r   <= status_nx_s;
      ovf_d_r    <= cnt_ovflw;
      cnt_zero_r <= clr_s;
      irq_r      <= irq_nx_s;
      if (rd_s) begin
        rdata_r <= rd_val_s;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign rdata    = rdata_r;
  assign cnt_zero = cnt_zero_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_cnt_sched.sv
// Scoreboard bench for cnt_sched: stimulus queues expected values, a monitor compares them.
// Expectations for the overflow scenario follow CNT_SCHED_OVF_IRQ_EN.
module tb_cnt_sched;

  logic        clk = 1'b0;
  logic        Rst;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] cnt_dout;
  logic        cnt_ovflw;
  logic        cnt_zero;
  logic        irq;
  logic        irq_ack;

  logic        ld;
  logic [31:0] ld_val;
  logic        chk_req;
  logic        chk_due;

  int n_chk  = 0;
  int n_fail = 0;

  localparam int K_RDATA = 0;
  localparam int K_IRQ   = 1;
  localparam int K_CZ    = 2;

`ifdef CNT_SCHED_OVF_IRQ_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];

  cnt_sched dut (
    .clk(clk), .Rst(Rst), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cnt_dout(cnt_dout), .cnt_ovflw(cnt_ovflw),
    .cnt_zero(cnt_zero), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // external free-running counter, cleared by cnt_zero, loadable by the bench
  always @(posedge clk) begin
    if (ld) cnt_dout <= ld_val;
    else if (cnt_zero) cnt_dout <= 32'd0;
    else cnt_dout <= cnt_dout + 32'd1;
    chk_due <= chk_req;
  end

  // monitor: whenever a sampled output is due, pop and compare
  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      if (chk_due === 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: output due but no expected value queued");
        end else begin
          e = q.pop_front();
          case (e.kind)
            K_RDATA: act = rdata;
            K_IRQ:   act = {31'd0, irq};
            default: act = {31'd0, cnt_zero};
          endcase
          if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] v, input string nm);
    cs = 1'b1; we = 1'b0; addr = a; chk_req = 1'b1;
    q.push_back('{kind: K_RDATA, val: v, name: nm});
    @(negedge clk);
    cs = 1'b0; chk_req = 1'b0;
  endtask

  task automatic sig_chk(input int k, input logic [31:0] v, input string nm);
    chk_req = 1'b1;
    q.push_back('{kind: k, val: v, name: nm});
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic wr_chk(input logic [2:0] a, input logic [31:0] d, input int k,
                        input logic [31:0] v, input string nm);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d; chk_req = 1'b1;
    q.push_back('{kind: k, val: v, name: nm});
    @(negedge clk);
    cs = 1'b0; we = 1'b0; chk_req = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic set_cnt(input logic [31:0] v);
    ld = 1'b1; ld_val = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic direct_chk(input string nm, input logic [31:0] act, input logic [31:0] v);
    n_chk++;
    if (act !== v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, v);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
    cnt_ovflw = 1'b0; irq_ack = 1'b0; ld = 1'b1; ld_val = 32'd0; chk_req = 1'b0;
    tick(3);
    ld = 1'b0;
    Rst = 1'b1;

    // reset values, mirror, unmapped offsets
    rd_chk(3'd0, 32'd0, "reset_ctrl");
    rd_chk(3'd3, 32'd0, "reset_status");
    rd_chk(3'd2, 32'd0, "reset_cmp1");
    sig_chk(K_IRQ, 32'd0, "reset_irq");
    set_cnt(32'd1000);
    rd_chk(3'd4, 32'd1000, "cnt_mirror_a");
    rd_chk(3'd4, 32'd1001, "cnt_mirror_b");
    wr(3'd5, 32'hDEADBEEF);
    rd_chk(3'd5, 32'd0, "unmapped_read");
    wr(3'd1, 32'd100);
    rd_chk(3'd1, 32'd100, "cmp0_readback");

    // one-shot: CMP0=100 armed at cnt=50, matches at 150, never again
    set_cnt(32'd50);
    wr(3'd0, 32'h05);
    tick(98);
    rd_chk(3'd3, 32'd0, "oneshot_status_before");
    sig_chk(K_IRQ, 32'd0, "oneshot_irq_match_cycle");
    sig_chk(K_IRQ, 32'd1, "oneshot_irq_set");
    rd_chk(3'd3, 32'd1, "oneshot_status_set");
    wr(3'd3, 32'd1);
    tick(110);
    rd_chk(3'd3, 32'd0, "oneshot_no_refire_status");
    sig_chk(K_IRQ, 32'd0, "oneshot_no_refire_irq");

    // periodic CH1 across the 32-bit wrap: matches at 0x10, 0x30, 0x50
    wr(3'd0, 32'h00);
    wr(3'd2, 32'h20);
    set_cnt(32'hFFFF_FFF0);
    wr(3'd0, 32'h29);
    tick(31);
    for (int m = 0; m < 3; m++) begin
      sig_chk(K_IRQ, 32'd0, "per_irq_before");
      sig_chk(K_IRQ, 32'd1, "per_irq_set");
      ack();
      sig_chk(K_IRQ, 32'd0, "per_irq_acked");
      if (m < 2) tick(28);
    end

    // both channels match together; acks service CH0 first
    wr(3'd0, 32'h00);
    wr(3'd1, 32'h40);
    wr(3'd2, 32'h40);
    set_cnt(32'h100);
    wr(3'd0, 32'h0D);
    tick(65);
    rd_chk(3'd3, 32'd3, "prio_both_pending");
    ack();
    rd_chk(3'd3, 32'd2, "prio_after_ack1");
    sig_chk(K_IRQ, 32'd1, "prio_irq_still_high");
    ack();
    rd_chk(3'd3, 32'd0, "prio_after_ack2");
    sig_chk(K_IRQ, 32'd0, "prio_irq_dropped");

    // W1C in the very cycle the match sets the bit: set wins
    wr(3'd0, 32'h00);
    set_cnt(32'h200);
    wr(3'd0, 32'h05);
    tick(63);
    wr(3'd3, 32'd1);
    rd_chk(3'd3, 32'd1, "set_beats_w1c");
    wr(3'd3, 32'd7);
    rd_chk(3'd3, 32'd0, "w1c_clears");

    // CLR: one-cycle cnt_zero, CH0 with CMP0=10 fires at cnt=10
    wr(3'd0, 32'h00);
    wr(3'd1, 32'd10);
    set_cnt(32'd5000);
    wr_chk(3'd0, 32'h07, K_CZ, 32'd1, "clr_cnt_zero_high");
    sig_chk(K_CZ, 32'd0, "clr_cnt_zero_one_cycle");
    rd_chk(3'd0, 32'h05, "clr_reads_zero");
    rd_chk(3'd4, 32'd1, "clr_counter_restarted");
    tick(8);
    sig_chk(K_IRQ, 32'd0, "clr_irq_before");
    rd_chk(3'd3, 32'd1, "clr_fire_at_10");
    sig_chk(K_IRQ, 32'd1, "clr_irq_set");

    // overflow source
    wr(3'd3, 32'd7);
    wr(3'd0, 32'h41);
    rd_chk(3'd0, OVF ? 32'h41 : 32'h01, "ovf_ctrl_readback");
    cnt_ovflw = 1'b1;
    tick(1);
    rd_chk(3'd3, OVF ? 32'h4 : 32'h0, "ovf_status");
    sig_chk(K_IRQ, {31'd0, OVF}, "ovf_irq");
    ack();
    rd_chk(3'd3, 32'd0, "ovf_acked");
    cnt_ovflw = 1'b0;

    // asynchronous reset while armed, pending, mid-read and mid-clear
    wr(3'd1, 32'd4);
    wr(3'd0, 32'h15);
    tick(10);
    rd_chk(3'd0, 32'h15, "pre_reset_ctrl");
    sig_chk(K_IRQ, 32'd1, "pre_reset_irq");
    wr(3'd0, 32'h17);
    Rst = 1'b0;
    #1;
    direct_chk("async_reset_rdata", rdata, 32'd0);
    direct_chk("async_reset_irq", {31'd0, irq}, 32'd0);
    direct_chk("async_reset_cnt_zero", {31'd0, cnt_zero}, 32'd0);
    tick(2);
    Rst = 1'b1;
    rd_chk(3'd0, 32'd0, "post_reset_ctrl");
    rd_chk(3'd1, 32'd0, "post_reset_cmp0");
    tick(10);
    rd_chk(3'd3, 32'd0, "post_reset_status");
    sig_chk(K_IRQ, 32'd0, "post_reset_irq");

    tick(3);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expected values never compared", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
